axi4l_cfg_master: RTL and testbench
===================================

# axi4l_cfg_master

AXI4-Lite initiator that converts single-beat commands from on-chip control logic into AXI4-Lite read and write transactions. It returns each transaction's response on a valid/ready response port. It sits on the requesting side of the dafx register bus and drives AXI4-Lite register slaves such as the dafx configuration register file. Only one transaction is outstanding at any time.

## Interface
- AXI_ADDR_WIDTH_P, 16: address width of the command port and the AXI address channels.
- AXI_DATA_WIDTH_P, 32: data width; must be 32 or 64.
- ERR_CNT_WIDTH_P, 16: width of the saturating error counter.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_WIDTH_P  byte address.
- cmd_wdata  in  AXI_DATA_WIDTH_P  write data.
- cmd_wstrb  in  AXI_DATA_WIDTH_P/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both high.
- rsp_write  out  1  echoes cmd_write.
- rsp_rdata  out  AXI_DATA_WIDTH_P  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_cnt  out  ERR_CNT_WIDTH_P  count of non-OKAY responses; saturates.
- awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master-side ports. Directions are mirrored relative to a slave. awprot and arprot are tied to 3'b000.

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr, data and strb, then go to WR_ADDR_DATA if cmd_write=1, otherwise RD_ADDR.
- WR_ADDR_DATA:
  - awvalid and wvalid are both asserted in the same cycle. The target slaves require both valid together.
  - Each valid deasserts independently after its own handshake. Track this with flags aw_done and w_done.
  - When both are done, go to WR_RESP. This includes the case where both handshakes happen in the same cycle.
- WR_RESP:
  - bready = 1.
  - On bvalid, capture bresp, set rsp_rdata = 0 and go to RESP.
- RD_ADDR: arvalid = 1; on the arready handshake go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata and rresp and go to RESP.
- RESP:
  - rsp_valid = 1 until rsp_ready, then go to IDLE.
  - cmd_ready stays 0 in this state, so there is no command/response overlap.
- Once asserted, every valid stays high with stable payload until its handshake completes.
- bready and rready are asserted only in WR_RESP and RD_DATA.
- err_cnt increments by 1 on each captured response with resp != 2'b00. It holds at all-ones.

## Timing
- Reset values:
  - All AXI outputs, rsp_* outputs, busy and err_cnt are 0.
  - cmd_ready is 0 while rst is high and 1 in the first cycle after release.
  - The FSM is in IDLE.
- Command accepted at edge N: awvalid/wvalid or arvalid is high from N+1.
- Zero-wait slave:
  - Read: rsp_valid at N+3 with arready in N+1 and rvalid in N+2.
  - Write: rsp_valid at N+3 with awready/wready in N+1 and bvalid in N+2.
- Back-to-back commands: the next cmd_ready comes one cycle after the rsp handshake.
- Reset mid-transaction: all valids drop immediately (asynchronous reset). The pending transaction and response are discarded, and err_cnt clears.
- bvalid or rvalid arriving outside the corresponding WAIT state is ignored; no ready is given.

## Structure
- Package axi4l_cfg_master_pkg contains:
  - the state enum axi4l_master_state_t;
  - the constants AXI_RESP_OKAY=2'b00, AXI_RESP_EXOKAY=2'b01, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
- The design is a single module with no sub-modules. The saturating counter is inline.

## Test plan
- Read 0x0000 with a zero-wait slave returning 0xBAADFACE/OKAY -> arvalid at N+1, rsp_valid at N+3, rsp_rdata=0xBAADFACE, rsp_resp=0, err_cnt=0.
- Write 0x0004 data 0x00000123 strb 0xF, slave delays wready by 3 cycles -> awvalid drops after 1 cycle, wvalid holds with stable payload, bready only after both handshakes, rsp_write=1, rsp_rdata=0.
- Slave accepts aw and w in the same cycle, bvalid 5 cycles later, rsp_ready held low 4 cycles -> rsp_valid, rsp_resp and rsp_rdata stable for all 4 cycles; cmd_ready=0 until the release.
- Three reads returning SLVERR, DECERR, OKAY -> err_cnt ends at 2. With ERR_CNT_WIDTH_P=2 and 5 errors -> err_cnt stays 3.
- Assert rst while in WR_RESP -> awvalid, wvalid, bready, busy all 0 immediately. After release, a new read completes normally and err_cnt=0.
- Random back-to-back mix against the dafx register slave model (1000 commands) -> read-after-write data matches the model; no valid drops before its ready; never more than one transaction outstanding.

Source files
------------

// File: rtl/axi4l_cfg_master_pkg.sv
// axi4l_cfg_master shared types and constants.
// State encoding plus AXI response codes.
package axi4l_cfg_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } axi4l_master_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(
    input logic [1:0] resp
  );
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4l_cfg_master_if.sv
// AXI4-Lite bus bundle between the config master and a register slave.
// Modports give the master and slave views.
interface axi4l_cfg_master_if #(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 32
);

  logic [AXI_ADDR_WIDTH_P-1:0]   awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [AXI_DATA_WIDTH_P-1:0]   wdata;
  logic [AXI_DATA_WIDTH_P/8-1:0] wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [AXI_ADDR_WIDTH_P-1:0]   araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [AXI_DATA_WIDTH_P-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4l_cfg_master.sv
// Single-outstanding AXI4-Lite initiator for register access.
// Command in, AXI transaction out, response back with error count.
module axi4l_cfg_master
  import axi4l_cfg_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int ERR_CNT_WIDTH_P  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH_P/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,
  output logic [ERR_CNT_WIDTH_P-1:0]    err_cnt,
  axi4l_cfg_master_if.master            axi
);

  axi4l_master_state_t state, state_n;

  logic [AXI_ADDR_WIDTH_P-1:0]   addr_q;
  logic [AXI_DATA_WIDTH_P-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH_P/8-1:0] wstrb_q;
  logic                          write_q;
  logic                          aw_done;
  logic                          w_done;
  logic [AXI_DATA_WIDTH_P-1:0]   rdata_q;
  logic [1:0]                    resp_q;
  logic [ERR_CNT_WIDTH_P-1:0]    err_q;

  logic       cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       cap;
  logic [1:0] cap_resp;

  // Handshakes are decoded from state so they never loop through the valids.
  assign cmd_ready = (state == IDLE) && !rst;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign aw_hs     = (state == WR_ADDR_DATA) && !aw_done && axi.awready;
  assign w_hs      = (state == WR_ADDR_DATA) && !w_done && axi.wready;
  assign b_hs      = (state == WR_RESP) && axi.bvalid;
  assign ar_hs     = (state == RD_ADDR) && axi.arready;
  assign r_hs      = (state == RD_DATA) && axi.rvalid;
  assign cap       = b_hs || r_hs;
  assign cap_resp  = b_hs ? axi.bresp : axi.rresp;

  always_comb begin
    state_n     = state;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_hs)
          state_n = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs))
          state_n = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (b_hs)
          state_n = RESP;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (ar_hs)
          state_n = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        if (r_hs)
          state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
      err_q   <= '0;
    end else begin
      state <= state_n;
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs)
        aw_done <= 1'b1;
      if (w_hs)
        w_done <= 1'b1;
      if (b_hs) begin
        resp_q  <= axi.bresp;
        rdata_q <= '0;
      end
      if (r_hs) begin
        resp_q  <= axi.rresp;
        rdata_q <= axi.rdata;
      end
      // Saturating count of non-OKAY responses.
      if (cap && resp_is_err(cap_resp) && (err_q != '1))
        err_q <= err_q + ERR_CNT_WIDTH_P'(1);
    end
  end

  assign axi.awaddr = addr_q;
  assign axi.awprot = 3'b000;
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = wstrb_q;
  assign axi.araddr = addr_q;
  assign axi.arprot = 3'b000;

  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state != IDLE);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_axi4l_cfg_master.sv
// Directed bench for axi4l_cfg_master with a delay-programmable register slave.
// A second instance with a 2-bit error counter runs in lockstep.
module tb_axi4l_cfg_master;
  import axi4l_cfg_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_ready = 1'b0;

  logic        cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_cnt;

  logic        cmd_ready2, rsp_valid2, rsp_write2, busy2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  rsp_resp2;
  logic [1:0]  err_cnt2;

  axi4l_cfg_master_if #(16, 32) bus ();
  axi4l_cfg_master_if #(16, 32) bus2 ();

  axi4l_cfg_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy),
    .err_cnt(err_cnt), .axi(bus)
  );

  axi4l_cfg_master #(.ERR_CNT_WIDTH_P(2)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write2), .rsp_rdata(rsp_rdata2),
    .rsp_resp(rsp_resp2), .busy(busy2),
    .err_cnt(err_cnt2), .axi(bus2)
  );

  assign bus2.awready = bus.awready;
  assign bus2.wready  = bus.wready;
  assign bus2.bresp   = bus.bresp;
  assign bus2.bvalid  = bus.bvalid;
  assign bus2.arready = bus.arready;
  assign bus2.rdata   = bus.rdata;
  assign bus2.rresp   = bus.rresp;
  assign bus2.rvalid  = bus.rvalid;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // slave model
  int aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_v = AXI_RESP_OKAY;
  logic [1:0] rresp_v = AXI_RESP_OKAY;
  logic [31:0] mem [16];

  task automatic chan(input logic v, input logic h, input int dly,
                      inout int cnt, inout logic rdy);
    if (h) rdy = 1'b0;
    else if (v) begin
      if (!rdy) begin
        if (cnt > 0) cnt--;
        if (cnt == 0) rdy = 1'b1;
      end
    end else begin
      cnt = dly;
      rdy = (dly == 0);
    end
  endtask

  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_r, w_r, ar_r, aw_got, w_got, b_pend, r_pend;
    logic awv, awr, wv, wr, bv, br, arv, arr, rv, rr, rst_s;
    logic [15:0] awa, ara, wa, ra;
    logic [31:0] wdt, wd;
    logic [3:0] wst, ws;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'hBAADFACE;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_r = 1'b0; w_r = 1'b0; ar_r = 1'b0;
    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    wa = '0; ra = '0; wd = '0; ws = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = '0;
    bus.rvalid = 1'b0; bus.rresp = '0; bus.rdata = '0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      awv = bus.awvalid; awr = bus.awready; awa = bus.awaddr;
      wv = bus.wvalid; wr = bus.wready; wdt = bus.wdata; wst = bus.wstrb;
      bv = bus.bvalid; br = bus.bready;
      arv = bus.arvalid; arr = bus.arready; ara = bus.araddr;
      rv = bus.rvalid; rr = bus.rready;
      #1;
      if (rst_s) begin
        aw_cnt = aw_dly; aw_r = (aw_dly == 0);
        w_cnt = w_dly; w_r = (w_dly == 0);
        ar_cnt = r_dly; ar_r = 1'b1;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
      end else begin
        chan(awv, awv && awr, aw_dly, aw_cnt, aw_r);
        chan(wv, wv && wr, w_dly, w_cnt, w_r);
        chan(arv, arv && arr, 0, ar_cnt, ar_r);
        if (awv && awr) begin wa = awa; aw_got = 1'b1; end
        if (wv && wr) begin wd = wdt; ws = wst; w_got = 1'b1; end
        if (bv && br) bus.bvalid = 1'b0;
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[wa[5:2]][8*b +: 8] = wd[8*b +: 8];
          aw_got = 1'b0; w_got = 1'b0;
          b_pend = 1'b1; b_cnt = b_dly;
        end
        if (b_pend) begin
          if (b_cnt == 0) begin
            bus.bvalid = 1'b1; bus.bresp = bresp_v; b_pend = 1'b0;
          end else b_cnt--;
        end
        if (rv && rr) bus.rvalid = 1'b0;
        if (arv && arr) begin r_pend = 1'b1; r_cnt = r_dly; ra = ara; end
        if (r_pend) begin
          if (r_cnt == 0) begin
            bus.rvalid = 1'b1; bus.rdata = mem[ra[5:2]];
            bus.rresp = rresp_v; r_pend = 1'b0;
          end else r_cnt--;
        end
      end
      bus.awready = aw_r;
      bus.wready  = w_r;
      bus.arready = ar_r;
    end
  end

  // protocol monitor
  logic mon_en = 1'b0;
  int   viol = 0;

  initial begin
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [15:0] p_awa, p_ara;
    logic [31:0] p_wd;
    logic [3:0] p_ws;
    int outst, tx;
    p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
    p_arv = 1'b0; p_arr = 1'b0; p_awa = '0; p_ara = '0; p_wd = '0; p_ws = '0;
    outst = 0; tx = 0;
    forever begin
      @(posedge clk);
      if (mon_en) begin
        if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awa)) viol++;
        if (p_wv && !p_wr &&
            (!bus.wvalid || bus.wdata != p_wd || bus.wstrb != p_ws)) viol++;
        if (p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_ara)) viol++;
        if (cmd_valid && cmd_ready) outst++;
        if (rsp_valid && rsp_ready) outst--;
        if (bus.arvalid && bus.arready) tx++;
        if (bus.awvalid && bus.awready) tx++;
        if (bus.rvalid && bus.rready) tx--;
        if (bus.bvalid && bus.bready) tx--;
        if (outst > 1 || tx > 1) viol++;
      end
      p_awv = bus.awvalid; p_awr = bus.awready; p_awa = bus.awaddr;
      p_wv = bus.wvalid; p_wr = bus.wready; p_wd = bus.wdata; p_ws = bus.wstrb;
      p_arv = bus.arvalid; p_arr = bus.arready; p_ara = bus.araddr;
    end
  end

  task automatic do_cmd(input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic [1:0] rs,
                        output logic rw);
    int t;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    if (!cmd_ready) chk("cmd_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    t = 0;
    while (!rsp_valid && t < 100) begin tick(); t++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] ref_mem [16];

  initial begin
    logic [31:0] rd, d;
    logic [1:0] rs;
    logic rw, wr;
    logic [3:0] s, idx;
    int t;

    // reset state
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 0);
    chk("rst_busy_err", {busy, err_cnt}, 0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // zero-wait read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    chk("rd_arvalid_n1", {bus.arvalid, rsp_valid}, 2'b10);
    tick();
    chk("rd_rready_n2", {bus.rready, rsp_valid}, 2'b10);
    tick();
    chk("rd_rsp_valid_n3", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 32'hBAADFACE);
    chk("rd_resp_err", {rsp_resp, err_cnt}, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_next_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);

    // write with wready delayed 3 cycles
    w_dly = 3;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0004;
    cmd_wdata = 32'h00000123; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("wr_both_valid", {bus.awvalid, bus.wvalid}, 2'b11);
    tick();
    chk("wr_aw_drop", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    tick();
    tick();
    chk("wr_w_hold", {bus.wvalid, bus.bready, bus.wdata, bus.wstrb},
        {1'b1, 1'b0, 32'h00000123, 4'hF});
    tick();
    chk("wr_bready", {bus.wvalid, bus.bready}, 2'b01);
    tick();
    chk("wr_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
        {1'b1, 1'b1, 2'b00, 32'h0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // aw/w in the same cycle, slow bvalid, stalled response
    w_dly = 0; b_dly = 5;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0008;
    cmd_wdata = 32'hCAFE0008; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("same_both_valid", {bus.awvalid, bus.wvalid}, 2'b11);
    tick();
    chk("same_to_wr_resp", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    t = 0;
    while (!rsp_valid && t < 20) begin tick(); t++; end
    chk("same_b_latency", t, 6);
    for (int k = 0; k < 4; k++) begin
      chk("stall_hold", {rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready},
          {1'b1, 1'b1, 2'b00, 32'h0, 1'b0});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stall_release", {cmd_ready, rsp_valid}, 2'b10);
    b_dly = 0;

    // error counting
    rresp_v = AXI_RESP_SLVERR;
    do_cmd(1'b0, 16'h0000, '0, '0, rd, rs, rw);
    chk("err_slverr", rs, AXI_RESP_SLVERR);
    rresp_v = AXI_RESP_DECERR;
    do_cmd(1'b0, 16'h0000, '0, '0, rd, rs, rw);
    chk("err_decerr", rs, AXI_RESP_DECERR);
    rresp_v = AXI_RESP_OKAY;
    do_cmd(1'b0, 16'h0000, '0, '0, rd, rs, rw);
    chk("err_cnt_2", err_cnt, 2);
    chk("err_cnt2_2", err_cnt2, 2);
    rresp_v = AXI_RESP_SLVERR;
    do_cmd(1'b0, 16'h0000, '0, '0, rd, rs, rw);
    do_cmd(1'b0, 16'h0000, '0, '0, rd, rs, rw);
    rresp_v = AXI_RESP_DECERR;
    do_cmd(1'b0, 16'h0000, '0, '0, rd, rs, rw);
    chk("err_cnt_5", err_cnt, 5);
    chk("err_cnt2_sat", err_cnt2, 3);
    rresp_v = AXI_RESP_OKAY;

    // reset while waiting for bvalid
    b_dly = 10;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h000C;
    cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    t = 0;
    while (!bus.bready && t < 10) begin tick(); t++; end
    chk("mid_in_wr_resp", bus.bready, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_drop", {bus.awvalid, bus.wvalid, bus.bready, busy}, 0);
    chk("mid_rst_err", {err_cnt, rsp_valid, cmd_ready}, 0);
    tick();
    tick();
    b_dly = 0;
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", cmd_ready, 1);
    do_cmd(1'b0, 16'h0004, '0, '0, rd, rs, rw);
    chk("mid_read_data", {rd, rs, rw}, {32'h00000123, 2'b00, 1'b0});
    chk("mid_err_clear", err_cnt, 0);

    // random back-to-back traffic against the register model
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      do_cmd(1'b1, 16'(i * 4), d, 4'hF, rd, rs, rw);
    end
    for (int n = 0; n < 1000; n++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      wr  = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      if (wr) begin
        do_cmd(1'b1, {10'h0, idx, 2'b00}, d, s, rd, rs, rw);
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        chk("rnd_wr_rsp", {rw, rd}, {1'b1, 32'h0});
      end else begin
        do_cmd(1'b0, {10'h0, idx, 2'b00}, '0, '0, rd, rs, rw);
        chk("rnd_rd_data", {rw, rd}, {1'b0, ref_mem[idx]});
      end
    end
    mon_en = 1'b0;
    chk("protocol_violations", viol, 0);
    chk("rnd_err_cnt", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
